// File: rtl/sobel_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_pkg
//  Description : Shared types, kernel weights and the per-channel gradient /
//                output-mode function for the streaming Sobel filter.
//                Contents:
//                  mode_e      - run-time output mode encoding
//                  state_e     - per-frame fill/run state
//                  c_K_EDGE    - Sobel kernel corner weight
//                  c_K_MID     - Sobel kernel centre-tap weight
//                  mag_w()     - magnitude width for a given sample width
//                  sobel_pixel - one channel's 3x3 result for a given mode
//  Revision    : 1.0  initial release
// ============================================================================
package sobel_pkg;

  typedef enum logic [1:0] {
    MODE_CLAMP  = 2'd0,
    MODE_SCALE  = 2'd1,
    MODE_THRESH = 2'd2,
    MODE_BYPASS = 2'd3
  } mode_e;

  typedef enum logic [0:0] {
    S_FILL = 1'b0,
    S_RUN  = 1'b1
  } state_e;

  // Kernel weights, held at the internal arithmetic width so products need
  // no further extension.
  localparam logic signed [35:0] c_K_EDGE = 36'sd1;
  localparam logic signed [35:0] c_K_MID  = 36'sd2;

  // |Gx|+|Gy| is bounded by 8*(2^DW-1), which fits in DW+3 bits.
  function automatic int mag_w(input int dw);
    return dw + 3;
  endfunction

  function automatic logic signed [35:0] ext(input logic [31:0] v);
    return $signed({4'b0000, v});
  endfunction

  // Samples arrive zero-extended to 32 bits; the caller keeps the low DW bits
  // of the return value. Internal arithmetic is 36 bits signed, which covers
  // sample widths up to 28 bits without overflow.
  function automatic logic [31:0] sobel_pixel(
    input int          dw,
    input mode_e       mode,
    input logic [31:0] thresh,
    input logic [31:0] p00, input logic [31:0] p01, input logic [31:0] p02,
    input logic [31:0] p10, input logic [31:0] p11, input logic [31:0] p12,
    input logic [31:0] p20, input logic [31:0] p21, input logic [31:0] p22
  );
    logic signed [35:0] gx;
    logic signed [35:0] gy;
    logic [35:0] ax;
    logic [35:0] ay;
    logic [35:0] mag;
    logic [35:0] maxv;
    logic [35:0] res;
    gx = (c_K_EDGE * ext(p02) + c_K_MID * ext(p12) + c_K_EDGE * ext(p22))
       - (c_K_EDGE * ext(p00) + c_K_MID * ext(p10) + c_K_EDGE * ext(p20));
    gy = (c_K_EDGE * ext(p20) + c_K_MID * ext(p21) + c_K_EDGE * ext(p22))
       - (c_K_EDGE * ext(p00) + c_K_MID * ext(p01) + c_K_EDGE * ext(p02));
    ax   = (gx < 0) ? -gx : gx;
    ay   = (gy < 0) ? -gy : gy;
    mag  = ax + ay;
    maxv = (36'd1 << dw) - 36'd1;
    case (mode)
      MODE_CLAMP:  res = (mag > maxv) ? maxv : mag;
      // Keep the top DW bits of the DW+3 bit magnitude.
      MODE_SCALE:  res = mag >> (mag_w(dw) - dw);
      MODE_THRESH: res = (mag >= {4'b0000, thresh}) ? maxv : 36'd0;
      default:     res = {4'b0000, p11};
    endcase
    return res[31:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sobel_line_buf.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_line_buf
//  Description : Two-row line buffer for one channel. A single address (the
//                current column) is read and written each cycle: reads are
//                combinational and return the pre-write contents, so the row
//                above and the row two above are available on the transfer.
//  Ports       : i_clk    - clock
//                i_wr_en  - shift column i_addr down one row and store i_din
//                i_addr   - column address
//                i_din    - incoming sample (current row)
//                o_row1   - sample one row above at i_addr
//                o_row2   - sample two rows above at i_addr
//  Revision    : 1.0  initial release
// ============================================================================
module sobel_line_buf #(
  parameter int DW    = 8,
  parameter int DEPTH = 256,
  parameter int AW    = 8
) (
  input  logic          i_clk,
  input  logic          i_wr_en,
  input  logic [AW-1:0] i_addr,
  input  logic [DW-1:0] i_din,
  output logic [DW-1:0] o_row1,
  output logic [DW-1:0] o_row2
);

  // Contents are never reset: a new frame refills both rows before any
  // result depends on them.
  logic [DW-1:0] r_row1 [DEPTH];
  logic [DW-1:0] r_row2 [DEPTH];

  assign o_row1 = r_row1[i_addr];
  assign o_row2 = r_row2[i_addr];

  always_ff @(posedge i_clk) begin
    if (i_wr_en) begin
      r_row2[i_addr] <= r_row1[i_addr];
      r_row1[i_addr] <= i_din;
    end
  end

endmodule
`default_nettype wire

// File: rtl/sobel_stream_n.sv
`default_nettype none
// ============================================================================
//  Module      : sobel_stream_n
//  Description : Streaming per-channel 3x3 Sobel edge filter with run-time
//                output mode. One result per interior pixel, raster order.
//  Ports       : i_clk          - clock, rising edge
//                i_rst          - asynchronous reset, active low
//                i_vld          - input word valid
//                i_busy         - input backpressure (transfer: vld && !busy)
//                i_data         - CH packed DW-bit samples
//                i_mode         - 0 clamp, 1 scaled, 2 threshold, 3 bypass
//                i_thresh       - threshold for mode 2
//                o_result_busy  - sink backpressure
//                o_result_vld   - result valid
//                o_result_data  - CH packed DW-bit results
//                o_frame_done   - pulse as the last result of a frame leaves
//  Revision    : 1.0  initial release
// ============================================================================
module sobel_stream_n
  import sobel_pkg::*;
#(
  parameter int CH    = 3,
  parameter int DW    = 8,
  parameter int IMG_W = 256,
  parameter int IMG_H = 256
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_vld,
  output logic             i_busy,
  input  logic [CH*DW-1:0] i_data,
  input  logic [1:0]       i_mode,
  input  logic [DW-1:0]    i_thresh,
  input  logic             o_result_busy,
  output logic             o_result_vld,
  output logic [CH*DW-1:0] o_result_data,
  output logic             o_frame_done
);

  localparam int c_CW = $clog2(IMG_W);
  localparam int c_RW = $clog2(IMG_H);
  localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(IMG_W - 1);
  localparam logic [c_CW-1:0] c_COL_TWO  = c_CW'(2);
  localparam logic [c_RW-1:0] c_ROW_LAST = c_RW'(IMG_H - 1);
  localparam logic [c_RW-1:0] c_ROW_ONE  = c_RW'(1);

  logic [c_CW-1:0]  r_col;
  logic [c_RW-1:0]  r_row;
  state_e           r_state;
  mode_e            r_mode;
  logic [DW-1:0]    r_thresh;
  logic             r_s1_vld;
  logic             r_s1_last;
  logic             r_out_vld;
  logic             r_out_last;
  logic [CH*DW-1:0] r_out_data;
  logic [CH*DW-1:0] w_res;

  logic w_xfer;
  logic w_out_ready;
  logic w_s1_move;
  logic w_col_last;
  logic w_row_last;
  logic w_interior;

  // Backpressure only when the one-deep stage-1 slot is full and cannot drain;
  // built from registers and the sink's busy, never from i_vld.
  assign i_busy      = r_s1_vld && r_out_vld && o_result_busy;
  assign w_xfer      = i_vld && !i_busy;
  assign w_out_ready = !r_out_vld || !o_result_busy;
  assign w_s1_move   = r_s1_vld && w_out_ready;
  assign w_col_last  = (r_col == c_COL_LAST);
  assign w_row_last  = (r_row == c_ROW_LAST);
  assign w_interior  = (r_state == S_RUN) && (r_col >= c_COL_TWO);

  // Position counters, fill/run state and per-frame mode latch.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_col    <= '0;
      r_row    <= '0;
      r_state  <= S_FILL;
      r_mode   <= MODE_CLAMP;
      r_thresh <= '0;
    end else if (w_xfer) begin
      if (r_col == '0 && r_row == '0) begin
        r_mode   <= mode_e'(i_mode);
        r_thresh <= i_thresh;
      end
      if (w_col_last) begin
        r_col <= '0;
        if (w_row_last) begin
          r_row   <= '0;
          r_state <= S_FILL;
        end else begin
          r_row <= r_row + 1'b1;
          if (r_row == c_ROW_ONE) begin
            r_state <= S_RUN;
          end
        end
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  // Stage 1 marks that the window holds an interior neighbourhood; the result
  // is computed from the window as it moves into the output register. A new
  // transfer can only coincide with a full stage 1 when stage 1 is draining,
  // so the window it reads is still the pre-shift one.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_s1_vld   <= 1'b0;
      r_s1_last  <= 1'b0;
      r_out_vld  <= 1'b0;
      r_out_last <= 1'b0;
      r_out_data <= '0;
    end else begin
      if (w_xfer && w_interior) begin
        r_s1_vld  <= 1'b1;
        r_s1_last <= w_col_last && w_row_last;
      end else if (w_s1_move) begin
        r_s1_vld <= 1'b0;
      end

      if (w_s1_move) begin
        r_out_vld  <= 1'b1;
        r_out_data <= w_res;
        r_out_last <= r_s1_last;
      end else if (!o_result_busy) begin
        r_out_vld <= 1'b0;
      end
    end
  end

  assign o_result_vld  = r_out_vld;
  assign o_result_data = r_out_data;
  assign o_frame_done  = r_out_vld && r_out_last && !o_result_busy;

  for (genvar k = 0; k < CH; k++) begin : g_ch
    logic [DW-1:0] w_pix_in;
    logic [DW-1:0] w_up1;
    logic [DW-1:0] w_up2;
    logic [DW-1:0] r_win [3][3];
    logic [31:0]   w_pix;
    logic          w_unused_hi;

    assign w_pix_in = i_data[k*DW +: DW];

    sobel_line_buf #(
      .DW    (DW),
      .DEPTH (IMG_W),
      .AW    (c_CW)
    ) u_line_buf (
      .i_clk   (i_clk),
      .i_wr_en (w_xfer),
      .i_addr  (r_col),
      .i_din   (w_pix_in),
      .o_row1  (w_up1),
      .o_row2  (w_up2)
    );

    // Window row 0 is the oldest line, column 0 the oldest sample.
    always_ff @(posedge i_clk) begin
      if (w_xfer) begin
        for (int r = 0; r < 3; r++) begin
          r_win[r][0] <= r_win[r][1];
          r_win[r][1] <= r_win[r][2];
        end
        r_win[0][2] <= w_up2;
        r_win[1][2] <= w_up1;
        r_win[2][2] <= w_pix_in;
      end
    end

    assign w_pix = sobel_pixel(DW, r_mode, 32'(r_thresh),
                               32'(r_win[0][0]), 32'(r_win[0][1]), 32'(r_win[0][2]),
                               32'(r_win[1][0]), 32'(r_win[1][1]), 32'(r_win[1][2]),
                               32'(r_win[2][0]), 32'(r_win[2][1]), 32'(r_win[2][2]));

    assign w_res[k*DW +: DW] = w_pix[DW-1:0];
    assign w_unused_hi       = ^w_pix[31:DW];
  end

endmodule
`default_nettype wire

// File: tb/tb_sobel_stream_n.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sobel_stream_n
//  Description : Scoreboard bench for sobel_stream_n (CH=3, DW=8, 8x6 frames).
//                Expected results come from a direct 3x3 convolution over the
//                stored image; a monitor pops them as results transfer.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_sobel_stream_n;

  localparam int CH   = 3;
  localparam int DW   = 8;
  localparam int W    = 8;
  localparam int H    = 6;
  localparam int NRES = (W - 2) * (H - 2);

  localparam int KX [3][3] = '{'{-1, 0, 1}, '{-2, 0, 2}, '{-1, 0, 1}};
  localparam int KY [3][3] = '{'{-1, -2, -1}, '{0, 0, 0}, '{1, 2, 1}};

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             vld = 1'b0;
  logic             in_busy;
  logic [CH*DW-1:0] din = '0;
  logic [1:0]       mode = 2'd0;
  logic [DW-1:0]    thresh = '0;
  logic             res_busy = 1'b0;
  logic             res_vld;
  logic [CH*DW-1:0] dout;
  logic             fdone;

  sobel_stream_n #(.CH(CH), .DW(DW), .IMG_W(W), .IMG_H(H)) dut (
    .i_clk         (clk),
    .i_rst         (rst_n),
    .i_vld         (vld),
    .i_busy        (in_busy),
    .i_data        (din),
    .i_mode        (mode),
    .i_thresh      (thresh),
    .o_result_busy (res_busy),
    .o_result_vld  (res_vld),
    .o_result_data (dout),
    .o_frame_done  (fdone)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [CH*DW-1:0] data;
    logic             last;
  } exp_t;

  exp_t exp_q[$];
  int   img [CH][H][W];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   n_pop = 0;
  bit   hold = 1'b0;
  bit   rand_busy = 1'b0;
  bit   gaps = 1'b0;
  bit   stab_chk = 1'b0;
  bit   saw_ibusy = 1'b0;
  logic [CH*DW-1:0] stab_data;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: direct kernel convolution centred at image (r,c).
  function automatic int ref_chan(input int ch, input int r, input int c,
                                  input int md, input int th);
    int gx = 0;
    int gy = 0;
    int mag;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        gx += KX[i][j] * img[ch][r-1+i][c-1+j];
        gy += KY[i][j] * img[ch][r-1+i][c-1+j];
      end
    end
    mag = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
    case (md)
      0:       return (mag > 255) ? 255 : mag;
      1:       return mag / 8;
      2:       return (mag >= th) ? 255 : 0;
      default: return img[ch][r][c];
    endcase
  endfunction

  function automatic logic [CH*DW-1:0] pix_word(input int r, input int c);
    logic [CH*DW-1:0] w;
    for (int ch = 0; ch < CH; ch++) w[ch*DW +: DW] = 8'(img[ch][r][c]);
    return w;
  endfunction

  task automatic push_expected(input int md, input int th);
    exp_t e;
    for (int r = 1; r <= H - 2; r++) begin
      for (int c = 1; c <= W - 2; c++) begin
        for (int ch = 0; ch < CH; ch++) e.data[ch*DW +: DW] = 8'(ref_chan(ch, r, c, md, th));
        e.last = (r == H - 2) && (c == W - 2);
        exp_q.push_back(e);
      end
    end
  endtask

  // 0: flat 100; 1: ch0 vertical step; 2: ch0 vstep, ch1 flat, ch2 hstep;
  // otherwise random.
  task automatic fill(input int pat);
    for (int ch = 0; ch < CH; ch++)
      for (int r = 0; r < H; r++)
        for (int c = 0; c < W; c++) begin
          case (pat)
            0: img[ch][r][c] = 100;
            1: img[ch][r][c] = (ch == 0) ? ((c < 4) ? 0 : 255) : 100;
            2: img[ch][r][c] = (ch == 0) ? ((c < 4) ? 0 : 255) :
                               (ch == 1) ? 60 : ((r < 3) ? 0 : 255);
            default: img[ch][r][c] = int'($urandom_range(0, 255));
          endcase
        end
  endtask

  // Tasks begin and end 1 time unit after a rising edge.
  task automatic send_word(input logic [CH*DW-1:0] w);
    int   guard = 0;
    logic b;
    if (gaps) repeat ($urandom_range(0, 1)) begin @(posedge clk); #1; end
    vld = 1'b1;
    din = w;
    do begin
      @(negedge clk);
      b = in_busy;
      @(posedge clk);
      #1;
      guard++;
    end while (b && guard < 1000);
    if (b) begin
      n_cmp++;
      n_fail++;
      $display("FAIL send_timeout: input stayed busy for %0d cycles", guard);
    end
    vld = 1'b0;
  endtask

  task automatic run_frame(input int md, input int th, input int switch_at,
                           input int new_md, input int npix);
    push_expected(md, th);
    mode   = 2'(md);
    thresh = 8'(th);
    for (int idx = 0; idx < npix; idx++) begin
      if (idx == switch_at) mode = 2'(new_md);
      send_word(pix_word(idx / W, idx % W));
    end
  endtask

  task automatic drain(input int start, input int n);
    int g = 0;
    while (exp_q.size() != 0 && g < 2000) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain_empty", exp_q.size(), 0);
    check("result_count", n_pop - start, n);
  endtask

  task automatic check_outputs_zero(input string tag);
    check({tag, "_vld"}, res_vld, 0);
    check({tag, "_data"}, dout, 0);
    check({tag, "_ibusy"}, in_busy, 0);
    check({tag, "_fdone"}, fdone, 0);
  endtask

  // Sink backpressure, updated after the inputs each cycle.
  initial begin
    forever begin
      @(posedge clk);
      #2;
      res_busy = hold || (rand_busy && ($urandom_range(0, 3) == 0));
    end
  end

  // Monitor: holds stable under backpressure and scoreboard pops.
  always @(negedge clk) begin
    if (!rst_n) begin
      stab_chk = 1'b0;
    end else begin
      if (stab_chk) begin
        check("hold_vld", res_vld, 1);
        check("hold_data", dout, stab_data);
      end
      if (in_busy) saw_ibusy = 1'b1;
      if (res_vld && !res_busy) begin
        if (exp_q.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_result: got %0h, expected none", dout);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("result_data", dout, e.data);
          check("frame_done", fdone, e.last);
          n_pop++;
        end
      end else if (fdone) begin
        n_cmp++;
        n_fail++;
        $display("FAIL frame_done_idle: got 1, expected 0");
      end
      stab_chk  = res_vld && res_busy;
      stab_data = dout;
    end
  end

  initial begin
    int start;
    repeat (3) @(posedge clk);
    #1;
    check_outputs_zero("reset");
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Flat image: all gradients zero.
    fill(0);
    start = n_pop;
    run_frame(0, 0, -1, 0, W * H);
    drain(start, NRES);

    // Vertical step in ch0 under every mode.
    fill(1);
    for (int md = 0; md < 4; md++) begin
      start = n_pop;
      run_frame(md, 200, -1, 0, W * H);
      drain(start, NRES);
    end

    // Independent channels.
    fill(2);
    start = n_pop;
    run_frame(0, 0, -1, 0, W * H);
    drain(start, NRES);

    // Sink held busy for 5 cycles mid-frame with input streaming.
    fill(3);
    saw_ibusy = 1'b0;
    start = n_pop;
    fork
      run_frame(0, 0, -1, 0, W * H);
      begin
        repeat (30) @(posedge clk);
        #1;
        hold = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        hold = 1'b0;
      end
    join
    drain(start, NRES);
    check("ibusy_seen", saw_ibusy, 1);

    // Mode change mid-frame applies from the next frame on.
    fill(3);
    start = n_pop;
    run_frame(0, 0, 20, 2, W * H);
    run_frame(2, 150, -1, 0, W * H);
    drain(start, 2 * NRES);

    // Reset after 20 transfers drops the partial frame.
    fill(3);
    run_frame(1, 0, -1, 0, 20);
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs_zero("midreset");
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    fill(3);
    start = n_pop;
    run_frame(0, 0, -1, 0, W * H);
    drain(start, NRES);

    // Random images, modes, gaps and sink backpressure.
    rand_busy = 1'b1;
    gaps      = 1'b1;
    repeat (4) begin
      fill(3);
      start = n_pop;
      run_frame(int'($urandom_range(0, 3)), int'($urandom_range(0, 255)), -1, 0, W * H);
      drain(start, NRES);
    end
    rand_busy = 1'b0;
    gaps      = 1'b0;
    repeat (5) @(posedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
